// File: rtl/dlfloat_dot_acc.sv
// dlfloat_dot_acc: DLFloat16 dot-product accumulator, VEC_LEN products per result.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair present
//   in_ready   pair can be accepted this cycle (IDLE or ACCUM, not in reset)
//   in_a       DLFloat16 operand A
//   in_b       DLFloat16 operand B
//   out_valid  dot-product result present
//   out_ready  consumer takes the result
//   out_data   DLFloat16 dot-product result
//   busy       any state other than IDLE
//
// Format: sign [15], exponent [14:9] biased by 31, mantissa [8:0] with hidden 1.
// 0x0000 is zero; 0xFFFF is a sticky special value.
//
// Optional macro DLMAC_SAT_EN: when defined, exponents above 62 saturate to
// 0xFFFF and exponents below 1 flush to 0x0000; otherwise they wrap modulo 64.
module dlfloat_dot_acc #(
    parameter int VEC_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy
);
    localparam int CNT_W = $clog2(VEC_LEN + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    // Final exponent range handling; e is a signed 8-bit exponent.
    function automatic logic [15:0] pack(input logic s, input logic [7:0] e, input logic [8:0] m);
`ifdef DLMAC_SAT_EN
        if ($signed(e) > 8'sd62) return 16'hFFFF;
        if ($signed(e) < 8'sd1) return 16'h0000;
`endif
        return {s, 6'(e), m};
    endfunction

    // Left-shift needed to bring the leading one of v to bit 9.
    function automatic logic [3:0] lzc(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++)
            if (v[i]) n = 4'(9 - i);
        return n;
    endfunction

    function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
        logic [19:0] p;
        logic [7:0]  e;
        if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
        if (a == 16'h0000 || b == 16'h0000) return 16'h0000;
        p = 20'({1'b1, a[8:0]}) * 20'({1'b1, b[8:0]});
        e = {2'b0, a[14:9]} + {2'b0, b[14:9]} + {7'b0, p[19]} - 8'd31;
        return pack(a[15] ^ b[15], e, p[19] ? 9'(p >> 10) : 9'(p >> 9));
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] l, s;
        logic [9:0]  ml, ms, diff;
        logic [10:0] sum;
        logic [3:0]  sh;
        if (x == 16'hFFFF || y == 16'hFFFF) return 16'hFFFF;
        if (x == 16'h0000) return y;
        if (y == 16'h0000) return x;
        // l holds the larger magnitude, so ml - ms never underflows.
        {l, s} = (x[14:0] >= y[14:0]) ? {x, y} : {y, x};
        ml   = {1'b1, l[8:0]};
        ms   = {1'b1, s[8:0]} >> (l[14:9] - s[14:9]);
        sum  = {1'b0, ml} + {1'b0, ms};
        diff = ml - ms;
        sh   = lzc(diff);
        if (l[15] == s[15])
            return sum[10] ? pack(l[15], {2'b0, l[14:9]} + 8'd1, 9'(sum >> 1))
                           : pack(l[15], {2'b0, l[14:9]}, 9'(sum));
        if (diff == 10'd0) return 16'h0000;
        return pack(l[15], {2'b0, l[14:9]} - {4'b0, sh}, 9'(diff << sh));
    endfunction

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      prod_q, acc_q, out_data_q, prod_d, acc_d;
    logic             pv_q, out_valid_q, accept, last;

    assign in_ready  = !rst && (state_q == IDLE || state_q == ACCUM);
    assign accept    = in_valid && in_ready;
    assign last      = cnt_q == CNT_W'(VEC_LEN - 1);
    assign prod_d    = fmul(in_a, in_b);
    assign acc_d     = fadd(acc_q, prod_q);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = state_q != IDLE;

    // pv_q marks a product waiting in stage 1; DRAIN ends once it has been folded in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prod_q      <= 16'h0000;
            pv_q        <= 1'b0;
            acc_q       <= 16'h0000;
            out_data_q  <= 16'h0000;
            out_valid_q <= 1'b0;
        end else begin
            pv_q <= accept;
            if (accept) begin
                prod_q <= prod_d;
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            if (pv_q) acc_q <= acc_d;
            case (state_q)
                IDLE, ACCUM: if (accept) state_q <= last ? DRAIN : ACCUM;
                DRAIN: if (!pv_q) begin
                    state_q     <= HOLD;
                    out_valid_q <= 1'b1;
                    out_data_q  <= acc_q;
                end
                HOLD: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    acc_q       <= 16'h0000;
                    cnt_q       <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dlfloat_dot_acc.sv
// tb_dlfloat_dot_acc: directed checks of the DLFloat16 dot-product accumulator.
module tb_dlfloat_dot_acc;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
    logic [15:0] in_a = 16'h0, in_b = 16'h0, out_data;
    logic        v1 = 1'b0, rdy1, ov1, ordy1 = 1'b0, busy1;
    logic [15:0] a1 = 16'h0, b1 = 16'h0, od1;
    int          checks = 0, failures = 0;

`ifdef DLMAC_SAT_EN
    localparam logic [15:0] EXP_BIG = 16'hFFFF;
`else
    localparam logic [15:0] EXP_BIG = 16'h3A00;
`endif

    always #5 clk = ~clk;

    dlfloat_dot_acc #(.VEC_LEN(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    dlfloat_dot_acc #(.VEC_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
        .in_a(a1), .in_b(b1), .out_valid(ov1), .out_ready(ordy1),
        .out_data(od1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", 16'(in_ready), 16'd1);
        @(negedge clk);
    endtask

    task automatic pause(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_rise", 16'(out_valid), 16'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 16'(in_ready), 16'd0);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_in_ready1", 16'(rdy1), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 16'(in_ready), 16'd1);
        chk("idle_busy", 16'(busy), 16'd0);

        // VEC_LEN=1: exponent 62+62-31 is out of range
        chk("v1_ready", 16'(rdy1), 16'd1);
        v1 = 1'b1; a1 = 16'h7C00; b1 = 16'h7C00;
        @(negedge clk);
        v1 = 1'b0;
        chk("v1_busy", 16'(busy1), 16'd1);
        chk("v1_early", 16'(ov1), 16'd0);
        repeat (2) @(negedge clk);
        chk("v1_valid", 16'(ov1), 16'd1);
        chk("v1_data", od1, EXP_BIG);
        ordy1 = 1'b1;
        @(negedge clk);
        chk("v1_release", 16'(ov1), 16'd0);

        // four 1.0*1.0, latency and hold with out_ready low
        repeat (4) push(16'h3E00, 16'h3E00);
        in_valid = 1'b0;
        chk("lat_busy", 16'(busy), 16'd1);
        chk("lat_t0", 16'(out_valid), 16'd0);
        @(negedge clk);
        chk("lat_t1", 16'(out_valid), 16'd0);
        @(negedge clk);
        chk("lat_t2", 16'(out_valid), 16'd1);
        chk("sum4_data", out_data, 16'h4200);
        chk("sum4_busy", 16'(busy), 16'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_data", out_data, 16'h4200);
            chk("hold_valid", 16'(out_valid), 16'd1);
            chk("hold_ready", 16'(in_ready), 16'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", 16'(in_ready), 16'd1);
        chk("release_valid", 16'(out_valid), 16'd0);
        chk("release_busy", 16'(busy), 16'd0);

        // cancellation with gaps; also proves the accumulator restarted at zero
        push(16'h3E00, 16'h3E00);
        pause(1);
        chk("gap_ready", 16'(in_ready), 16'd1);
        chk("gap_busy", 16'(busy), 16'd1);
        push(16'hBE00, 16'h3E00);
        pause(2);
        push(16'h0000, 16'h4000);
        pause(3);
        push(16'h4000, 16'h0000);
        in_valid = 1'b0;
        wait_out();
        chk("cancel_data", out_data, 16'h0000);
        @(negedge clk);
        chk("handover_ready", 16'(in_ready), 16'd1);
        chk("handover_valid", 16'(out_valid), 16'd0);

        // special operand is sticky
        push(16'h3E00, 16'h3E00);
        push(16'hFFFF, 16'h3E00);
        push(16'h3E00, 16'h3E00);
        push(16'h3E00, 16'h3E00);
        in_valid = 1'b0;
        wait_out();
        chk("special_data", out_data, 16'hFFFF);
        @(negedge clk);

        // 2*3 - 1*1.5 + 1*0.75 - 2*4 = -2.75
        push(16'h4000, 16'h4100);
        push(16'hBE00, 16'h3F00);
        push(16'h3E00, 16'h3D00);
        push(16'hC000, 16'h4200);
        in_valid = 1'b0;
        wait_out();
        chk("mixed_data", out_data, 16'hC0C0);
        @(negedge clk);

        // 1.5*1.5 four times = 9.0 (product normalisation carry)
        repeat (4) push(16'h3F00, 16'h3F00);
        in_valid = 1'b0;
        wait_out();
        chk("carry_data", out_data, 16'h4440);
        @(negedge clk);

        // reset mid-vector
        out_ready = 1'b0;
        push(16'h3E00, 16'h3E00);
        push(16'h3E00, 16'h3E00);
        in_valid = 1'b0;
        chk("mid_no_valid", 16'(out_valid), 16'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 16'(in_ready), 16'd0);
        chk("mid_rst_busy", 16'(busy), 16'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_no_partial", 16'(out_valid), 16'd0);
        chk("mid_idle_busy", 16'(busy), 16'd0);
        out_ready = 1'b1;
        repeat (4) push(16'h3E00, 16'h3E00);
        in_valid = 1'b0;
        wait_out();
        chk("mid_data", out_data, 16'h4200);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
